exec_pipe_reg: RTL and testbench
================================

// Module: exec_pipe_reg
// PURPOSE
//  Parametrised EX->WB pipeline register chain: STAGES-deep shift of {valid, alu, alu_to_reg, rd}.
//  Supports stall (hold), flush (kill), and bubble insertion.
//  Provides two forwarding lookup ports that search every in-flight stage, so the decode stage can bypass results.
//  Sits between the ALU and the register-file write port.
// PARAMETERS
//  STAGES  2   number of register stages / latency in cycles, legal 1..4
//  DATA_W  32  width of ALU result
//  RD_W    5   width of destination register index
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       synchronous, active-high
//  stall          in   1       hold every stage this cycle
//  flush          in   1       kill every in-flight entry this cycle
//  in_valid       in   1       entry presented this cycle is real (0 = bubble)
//  alu_in         in   DATA_W  ALU result
//  alu_to_reg_in  in   1       entry writes register file
//  rd_in          in   RD_W    destination register
//  out_valid      out  1       output stage holds a real entry
//  alu            out  DATA_W  output-stage ALU result
//  alu_to_reg     out  1       output-stage write enable (never 1 when out_valid=0)
//  rd             out  RD_W    output-stage destination
//  busy           out  1       OR of all stage valid bits
//  fwd_rs1        in   RD_W    forwarding query 1
//  fwd_rs2        in   RD_W    forwarding query 2
//  fwd_hit1/2     out  1       query matched an in-flight writer
//  fwd_data1/2    out  DATA_W  data of matching entry, 0 when no hit
// BEHAVIOUR
//  - Stage 0 captures the inputs; stage STAGES-1 drives the outputs. Latency is exactly STAGES cycles.
//  - Priority per edge: reset > flush > stall > advance.
//  - Reset: all stages valid=0, alu=0, alu_to_reg=0, rd=0. Outputs read 0 from the first cycle after reset.
//    No X values are ever stored.
//  - Flush, including when stall is also high: every stage is set to valid=0, alu_to_reg=0, rd=0, alu=0.
//    The input on that cycle is discarded.
//  - Stall without flush: all stages, including the outputs, hold their values. The input is not captured.
//  - Advance: stage k+1 <= stage k; stage 0 <= inputs.
//    If in_valid=0, stage 0 is loaded with the bubble value {0,0,0,0}.
//    If in_valid=1, alu_to_reg is stored as given.
//  - Invariant: a stage with valid=0 always has alu_to_reg=0.
//  - Forwarding is combinational from stage registers only; there is no path from the inputs.
//    A hit on stage k requires valid & alu_to_reg & (rd == fwd_rsN) & (fwd_rsN != 0).
//    If several stages hit, the youngest (lowest k) wins.
//    On a miss, hit=0 and data=0.
//    During stall, forwarding still reflects the held stages.
//  - STAGES=1: a single register, with behaviour identical to the rules above.
// TESTING
//  1. STAGES=2, reset, then {v=1,alu=0x11,rd=3,wr=1} at c0 and {v=1,alu=0x22,rd=4,wr=1} at c1
//     -> outputs 0x11/3 at c2 and 0x22/4 at c3; out_valid=0 at c0-c1.
//  2. Stream 0x1..0x5 with stall high for 3 cycles mid-stream
//     -> outputs frozen during stall; sequence 0x1..0x5 arrives complete and in order.
//  3. Pipe full; flush=1 together with stall=1
//     -> next cycle out_valid=0, alu_to_reg=0, busy=0.
//     A new entry issued after the flush appears after STAGES cycles.
//  4. Stage 0 {rd=5,alu=0xAA,wr=1}, stage 1 {rd=5,alu=0xBB,wr=1}, rs1=5, rs2=0
//     -> fwd_hit1=1 with 0xAA; fwd_hit2=0 with 0.
//     Same setup with stage 0 wr=0 -> fwd_hit1=1 with 0xBB.
//  5. STAGES=1 and STAGES=4 builds: single entry 0x7
//     -> appears after exactly 1 and 4 cycles; a bubble (in_valid=0) yields out_valid=0, alu_to_reg=0.
//  6. Reset asserted mid-stream with stall=1 and flush=0
//     -> next cycle all outputs 0, busy=0, no fwd hits.

Source files
------------

// File: rtl/exec_pipe_reg_if.sv
// rtl/exec_pipe_reg_if.sv - EX->WB pipeline register bundle: issue, output stage and forwarding lookups
interface exec_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] alu_in;
  logic              alu_to_reg_in;
  logic [RD_W-1:0]   rd_in;
  logic              out_valid;
  logic [DATA_W-1:0] alu;
  logic              alu_to_reg;
  logic [RD_W-1:0]   rd;
  logic              busy;
  logic [RD_W-1:0]   fwd_rs1;
  logic [RD_W-1:0]   fwd_rs2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  modport master (
    output stall, flush, in_valid, alu_in, alu_to_reg_in, rd_in, fwd_rs1, fwd_rs2,
    input  out_valid, alu, alu_to_reg, rd, busy, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

  modport slave (
    input  stall, flush, in_valid, alu_in, alu_to_reg_in, rd_in, fwd_rs1, fwd_rs2,
    output out_valid, alu, alu_to_reg, rd, busy, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/exec_pipe_reg.sv
// rtl/exec_pipe_reg.sv - STAGES-deep EX->WB register chain with stall, flush and two forwarding ports
module exec_pipe_reg #(
  parameter int STAGES = 2,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  exec_pipe_reg_if.slave   bus
);
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_wr;
  logic [DATA_W-1:0] r_alu [STAGES];
  logic [RD_W-1:0]   r_rd  [STAGES];

  logic              w_hit1;
  logic              w_hit2;
  logic [DATA_W-1:0] w_data1;
  logic [DATA_W-1:0] w_data2;

  // Bubbles are stored as all-zero so an invalid stage can never look like a writer.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_valid <= '0;
      r_wr    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_alu[k] <= '0;
        r_rd[k]  <= '0;
      end
    end else if (!bus.stall) begin
      r_valid[0] <= bus.in_valid;
      r_wr[0]    <= bus.in_valid & bus.alu_to_reg_in;
      r_alu[0]   <= bus.in_valid ? bus.alu_in : '0;
      r_rd[0]    <= bus.in_valid ? bus.rd_in  : '0;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_wr[k]    <= r_wr[k-1];
        r_alu[k]   <= r_alu[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
    end
  end

  // Scan oldest to youngest so the youngest matching stage overwrites older hits.
  always_comb begin
    w_hit1  = 1'b0;
    w_hit2  = 1'b0;
    w_data1 = '0;
    w_data2 = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (r_valid[k] && r_wr[k] && (r_rd[k] == bus.fwd_rs1) && (bus.fwd_rs1 != '0)) begin
        w_hit1  = 1'b1;
        w_data1 = r_alu[k];
      end
      if (r_valid[k] && r_wr[k] && (r_rd[k] == bus.fwd_rs2) && (bus.fwd_rs2 != '0)) begin
        w_hit2  = 1'b1;
        w_data2 = r_alu[k];
      end
    end
  end

  assign bus.out_valid  = r_valid[STAGES-1];
  assign bus.alu        = r_alu[STAGES-1];
  assign bus.alu_to_reg = r_wr[STAGES-1];
  assign bus.rd         = r_rd[STAGES-1];
  assign bus.busy       = |r_valid;
  assign bus.fwd_hit1   = w_hit1;
  assign bus.fwd_hit2   = w_hit2;
  assign bus.fwd_data1  = w_data1;
  assign bus.fwd_data2  = w_data2;
endmodule

// File: tb/tb_exec_pipe_reg.sv
// tb/tb_exec_pipe_reg.sv - bench for exec_pipe_reg at depths 1, 2 and 4 driven by shared stimulus
module tb_exec_pipe_reg;
  typedef struct packed {
    logic        v;
    logic [31:0] alu;
    logic        wr;
    logic [4:0]  rd;
  } ent_t;
  typedef ent_t ent_q_t[$];

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid, wr_in;
  logic [31:0] alu_in;
  logic [4:0]  rd_in, rs1, rs2;
  int          passed = 0;
  int          total  = 0;
  bit          chk_en = 1'b0;
  ent_q_t      m1, m2, m4;

  always #5 clk = ~clk;

  exec_pipe_reg_if #(.DATA_W(32), .RD_W(5)) b1 ();
  exec_pipe_reg_if #(.DATA_W(32), .RD_W(5)) b2 ();
  exec_pipe_reg_if #(.DATA_W(32), .RD_W(5)) b4 ();

  assign b1.stall = stall;  assign b1.flush = flush;  assign b1.in_valid = in_valid;
  assign b1.alu_in = alu_in; assign b1.alu_to_reg_in = wr_in; assign b1.rd_in = rd_in;
  assign b1.fwd_rs1 = rs1;  assign b1.fwd_rs2 = rs2;
  assign b2.stall = stall;  assign b2.flush = flush;  assign b2.in_valid = in_valid;
  assign b2.alu_in = alu_in; assign b2.alu_to_reg_in = wr_in; assign b2.rd_in = rd_in;
  assign b2.fwd_rs1 = rs1;  assign b2.fwd_rs2 = rs2;
  assign b4.stall = stall;  assign b4.flush = flush;  assign b4.in_valid = in_valid;
  assign b4.alu_in = alu_in; assign b4.alu_to_reg_in = wr_in; assign b4.rd_in = rd_in;
  assign b4.fwd_rs1 = rs1;  assign b4.fwd_rs2 = rs2;

  exec_pipe_reg #(.STAGES(1), .DATA_W(32), .RD_W(5)) u_d1 (.clk(clk), .reset(reset), .bus(b1));
  exec_pipe_reg #(.STAGES(2), .DATA_W(32), .RD_W(5)) u_d2 (.clk(clk), .reset(reset), .bus(b2));
  exec_pipe_reg #(.STAGES(4), .DATA_W(32), .RD_W(5)) u_d4 (.clk(clk), .reset(reset), .bus(b4));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Reference: the pipe is the list of the last d accepted entries, youngest first.
  function automatic ent_q_t step_q(input ent_q_t q, input int d);
    ent_q_t r = q;
    if (reset || flush) begin
      r = {};
      for (int k = 0; k < d; k++) r.push_back('0);
    end else if (!stall) begin
      r.push_front(in_valid ? ent_t'{1'b1, alu_in, wr_in, rd_in} : ent_t'('0));
      void'(r.pop_back());
    end
    return r;
  endfunction

  function automatic logic [32:0] fwd_of(input ent_q_t q, input logic [4:0] rs);
    for (int k = 0; k < q.size(); k++)
      if (q[k].v && q[k].wr && q[k].rd == rs && rs != 5'd0) return {1'b1, q[k].alu};
    return 33'd0;
  endfunction

  function automatic logic busy_of(input ent_q_t q);
    foreach (q[k]) if (q[k].v) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    m1 = step_q(m1, 1);
    m2 = step_q(m2, 2);
    m4 = step_q(m4, 4);
  end

  task automatic cmp(input string nm, input ent_q_t q, input int d,
                     input logic ov, input logic [31:0] a, input logic w, input logic [4:0] r,
                     input logic bsy, input logic h1, input logic [31:0] d1,
                     input logic h2, input logic [31:0] d2);
    chk({nm, " out"},  {25'd0, ov, a, w, r}, {25'd0, q[d-1]});
    chk({nm, " busy"}, {63'd0, bsy}, {63'd0, busy_of(q)});
    chk({nm, " fwd1"}, {31'd0, h1, d1}, {31'd0, fwd_of(q, rs1)});
    chk({nm, " fwd2"}, {31'd0, h2, d2}, {31'd0, fwd_of(q, rs2)});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("d1", m1, 1, b1.out_valid, b1.alu, b1.alu_to_reg, b1.rd, b1.busy,
          b1.fwd_hit1, b1.fwd_data1, b1.fwd_hit2, b1.fwd_data2);
      cmp("d2", m2, 2, b2.out_valid, b2.alu, b2.alu_to_reg, b2.rd, b2.busy,
          b2.fwd_hit1, b2.fwd_data1, b2.fwd_hit2, b2.fwd_data2);
      cmp("d4", m4, 4, b4.out_valid, b4.alu, b4.alu_to_reg, b4.rd, b4.busy,
          b4.fwd_hit1, b4.fwd_data1, b4.fwd_hit2, b4.fwd_data2);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] a, input logic w, input logic [4:0] r);
    in_valid = v; alu_in = a; wr_in = w; rd_in = r;
  endtask

  task automatic do_flush;
    flush = 1'b1; drv(0, 0, 0, 0); tick; flush = 1'b0;
  endtask

  logic [31:0] got[$];
  logic [31:0] held;
  int          nxt;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; rs1 = '0; rs2 = '0;
    drv(0, 0, 0, 0);
    tick;
    chk_en = 1'b1;
    tick;
    reset = 1'b0;

    // Test 1: latency of two on the default depth
    chk("rst out_valid", {63'd0, b2.out_valid}, 64'd0);
    chk("rst busy", {63'd0, b2.busy | b1.busy | b4.busy}, 64'd0);
    drv(1, 32'h11, 1, 5'd3); tick;
    chk("t1 c1 out_valid", {63'd0, b2.out_valid}, 64'd0);
    drv(1, 32'h22, 1, 5'd4); tick;
    chk("t1 c2", {b2.out_valid, b2.alu, b2.rd}, {26'd0, 1'b1, 32'h11, 5'd3});
    drv(0, 0, 0, 0); tick;
    chk("t1 c3", {b2.out_valid, b2.alu, b2.rd}, {26'd0, 1'b1, 32'h22, 5'd4});

    // Test 2: stream 1..5 with a three-cycle stall
    do_flush;
    nxt = 1;
    for (int c = 0; c < 14; c++) begin
      stall = (c >= 2 && c <= 4);
      if (!stall && nxt <= 5) begin drv(1, nxt, 1, 5'd7); nxt++; end
      else drv(0, 0, 0, 0);
      held = b2.alu;
      tick;
      if (stall) chk("t2 frozen", {32'd0, b2.alu}, {32'd0, held});
      else if (b2.out_valid) got.push_back(b2.alu);
    end
    stall = 1'b0;
    chk("t2 count", 64'(got.size()), 64'd5);
    foreach (got[i]) chk("t2 order", {32'd0, got[i]}, 64'(i + 1));

    // Test 3: flush wins over stall on a full pipe
    for (int i = 0; i < 4; i++) begin drv(1, 32'h50 + i, 1, 5'd9); tick; end
    stall = 1'b1; flush = 1'b1; tick;
    stall = 1'b0; flush = 1'b0;
    chk("t3 flushed", {61'd0, b2.out_valid, b2.alu_to_reg, b2.busy | b4.busy}, 64'd0);
    drv(1, 32'h33, 1, 5'd2); tick;
    drv(0, 0, 1, 0); tick;
    chk("t3 reissue", {b2.out_valid, b2.alu}, {31'd0, 1'b1, 32'h33});

    // Test 4: youngest writer wins, rs=0 never hits, non-writer is skipped
    do_flush;
    drv(1, 32'hBB, 1, 5'd5); tick;
    drv(1, 32'hAA, 1, 5'd5); tick;
    stall = 1'b1; drv(0, 0, 0, 0); rs1 = 5'd5; rs2 = 5'd0; #1;
    chk("t4 fwd1 young", {b2.fwd_hit1, b2.fwd_data1}, {31'd0, 1'b1, 32'hAA});
    chk("t4 fwd2 zero", {b2.fwd_hit2, b2.fwd_data2}, 64'd0);
    stall = 1'b0;
    do_flush;
    drv(1, 32'hBB, 1, 5'd5); tick;
    drv(1, 32'hAA, 0, 5'd5); tick;
    stall = 1'b1; drv(0, 0, 0, 0); #1;
    chk("t4 fwd1 skip", {b2.fwd_hit1, b2.fwd_data1}, {31'd0, 1'b1, 32'hBB});
    stall = 1'b0; rs1 = '0;

    // Test 5: depth 1 and depth 4 latency, bubble with a stray write enable
    do_flush;
    drv(1, 32'h7, 1, 5'd1); tick;
    chk("t5 d1 lat", {b1.out_valid, b1.alu}, {31'd0, 1'b1, 32'h7});
    drv(0, 32'hFF, 1, 5'd3); tick;
    chk("t5 d1 bubble", {62'd0, b1.out_valid, b1.alu_to_reg}, 64'd0);
    tick;
    chk("t5 d4 early", {63'd0, b4.out_valid}, 64'd0);
    tick;
    chk("t5 d4 lat", {b4.out_valid, b4.alu}, {31'd0, 1'b1, 32'h7});
    tick;
    chk("t5 d4 bubble", {62'd0, b4.out_valid, b4.alu_to_reg}, 64'd0);

    // Test 6: reset beats stall mid-stream
    for (int i = 0; i < 3; i++) begin drv(1, 32'h90 + i, 1, 5'd6); tick; end
    rs1 = 5'd6; rs2 = 5'd6;
    reset = 1'b1; stall = 1'b1; tick;
    reset = 1'b0; stall = 1'b0;
    chk("t6 d4 zero", {b4.out_valid, b4.alu, b4.alu_to_reg, b4.rd, b4.busy}, 64'd0);
    chk("t6 d2 zero", {b2.out_valid, b2.alu, b2.alu_to_reg, b2.rd, b2.busy}, 64'd0);
    chk("t6 fwd", {60'd0, b4.fwd_hit1, b4.fwd_hit2, b2.fwd_hit1, b1.fwd_hit1}, 64'd0);

    // Randomised traffic against the reference
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 5);
      stall = ($urandom_range(0, 99) < 20);
      drv($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 3)));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      tick;
    end
    reset = 1'b0; flush = 1'b0; stall = 1'b0;
    tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
